// File: rtl/stepper_step_sequencer.sv
// APB-controlled step sequencer for one stepper axis: a period timer paces STEP/DIR pulses and coil-phase updates.
// Optional half-step drive is built when STEPSEQ_HALFSTEP_EN is defined.
module stepper_step_sequencer #(
  parameter int unsigned PULSE_W = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        STEP,
  output logic        DIR,
  output logic [3:0]  PHASE,
  output logic        IRQ
);

`ifdef STEPSEQ_HALFSTEP_EN
  localparam int unsigned IDX_W = 3;
`else
  localparam int unsigned IDX_W = 2;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_PER    = CNT_W'(PULSE_W + 2);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SETUP, S_PULSE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic               en_q, en_d;
  logic               dir_req_q, dir_req_d;
  logic               irq_en_q, irq_en_d;
  logic               done_q, done_d;
  logic               dir_q, dir_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        prdata_q, prdata_d;
`ifdef STEPSEQ_HALFSTEP_EN
  logic               half_q, half_d;
`endif

  logic               wr_stb, rd_stb, abort, done_set, done_clr, half_rd;
  logic [1:0]         sel;
  logic [CNT_W-1:0]   eff_per;
  logic [IDX_W-1:0]   idx_stepped;
  logic [31:0]        rd_data;
  logic               unused_apb_bits;

  assign wr_stb  = PSEL & PENABLE & PWRITE;
  assign rd_stb  = PSEL & ~PWRITE;
  assign sel     = PADDR[3:2];
  assign abort   = wr_stb && (sel == 2'd2) && PWDATA[3];
  assign eff_per = (period_q < MIN_PER) ? MIN_PER : period_q;
  assign unused_apb_bits = ^{PADDR[7:4], PADDR[1:0], PWDATA};

  function automatic logic [3:0] full_pat(input logic [1:0] k);
    case (k)
      2'd0:    full_pat = 4'b1000;
      2'd1:    full_pat = 4'b0100;
      2'd2:    full_pat = 4'b0010;
      default: full_pat = 4'b0001;
    endcase
  endfunction

`ifdef STEPSEQ_HALFSTEP_EN
  // Full-step mode keeps the 3-bit index even-spaced (2k) and moves it by 2.
  assign half_rd = half_q;
  always_comb begin
    if (half_q) idx_stepped = dir_req_q ? idx_q + IDX_ONE : idx_q - IDX_ONE;
    else        idx_stepped = dir_req_q ? idx_q + IDX_W'(2) : idx_q - IDX_W'(2);
  end

  always_comb begin
    if (half_q) begin
      case (idx_q)
        3'd0:    PHASE = 4'b1000;
        3'd1:    PHASE = 4'b1100;
        3'd2:    PHASE = 4'b0100;
        3'd3:    PHASE = 4'b0110;
        3'd4:    PHASE = 4'b0010;
        3'd5:    PHASE = 4'b0011;
        3'd6:    PHASE = 4'b0001;
        default: PHASE = 4'b1001;
      endcase
    end else begin
      PHASE = full_pat(idx_q[2:1]);
    end
  end
`else
  assign half_rd     = 1'b0;
  assign idx_stepped = dir_req_q ? idx_q + IDX_ONE : idx_q - IDX_ONE;
  assign PHASE       = full_pat(idx_q);
`endif

  always_comb begin
    rd_data = '0;
    case (sel)
      2'd0:    rd_data = 32'(period_q);
      2'd1:    rd_data = 32'(remaining_q);
      2'd2:    rd_data = {27'd0, irq_en_q, 1'b0, half_rd, dir_req_q, en_q};
      default: rd_data = {30'd0, done_q, state_q != S_IDLE};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    remaining_d = remaining_q;
    en_d        = en_q;
    dir_req_d   = dir_req_q;
    irq_en_d    = irq_en_q;
    dir_d       = dir_q;
    idx_d       = idx_q;
    prdata_d    = prdata_q;
    done_set    = 1'b0;
    done_clr    = 1'b0;
`ifdef STEPSEQ_HALFSTEP_EN
    half_d      = half_q;
`endif

    // DIR/phase/count update as SETUP is entered so DIR leads the STEP edge by a full cycle.
    unique case (state_q)
      S_IDLE: cnt_d = '0;
      S_WAIT: begin
        if (remaining_q == '0) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          done_set = 1'b1;
        end else if (en_q) begin
          if (cnt_q >= eff_per - CNT_ONE) begin
            state_d     = S_SETUP;
            cnt_d       = '0;
            dir_d       = dir_req_q;
            idx_d       = idx_stepped;
            remaining_d = remaining_q - CNT_ONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_SETUP: begin
        state_d = S_PULSE;
        cnt_d   = cnt_q + CNT_ONE;
      end
      S_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          if (remaining_q != '0) begin
            state_d = S_WAIT;
            cnt_d   = cnt_q + CNT_ONE;
          end else begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            done_set = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_stb) begin
      unique case (sel)
        2'd0: period_d = PWDATA[CNT_W-1:0];
        2'd1: begin
          remaining_d = PWDATA[CNT_W-1:0];
          if (state_d == S_IDLE && PWDATA[CNT_W-1:0] != '0) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
        2'd2: begin
          en_d      = PWDATA[0];
          dir_req_d = PWDATA[1];
          irq_en_d  = PWDATA[4];
          if (abort) begin
            state_d     = S_IDLE;
            remaining_d = '0;
            cnt_d       = '0;
            done_set    = 1'b0;
            dir_d       = dir_q;
            idx_d       = idx_q;
          end
`ifdef STEPSEQ_HALFSTEP_EN
          half_d = PWDATA[2];
          if (state_q == S_IDLE && half_q && !PWDATA[2]) idx_d = {idx_q[2:1], 1'b0};
`endif
        end
        default: done_clr = PWDATA[1];
      endcase
    end

    done_d = done_set | (done_q & ~done_clr);
    if (rd_stb) prdata_d = rd_data;
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      period_q    <= '0;
      remaining_q <= '0;
      en_q        <= 1'b0;
      dir_req_q   <= 1'b0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      dir_q       <= 1'b0;
      idx_q       <= '0;
      prdata_q    <= '0;
`ifdef STEPSEQ_HALFSTEP_EN
      half_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      remaining_q <= remaining_d;
      en_q        <= en_d;
      dir_req_q   <= dir_req_d;
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      dir_q       <= dir_d;
      idx_q       <= idx_d;
      prdata_q    <= prdata_d;
`ifdef STEPSEQ_HALFSTEP_EN
      half_q      <= half_d;
`endif
    end
  end

  assign STEP    = (state_q == S_PULSE);
  assign DIR     = dir_q;
  assign IRQ     = done_q & irq_en_q;
  assign PRDATA  = prdata_q;
  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;

endmodule

// File: tb/tb_stepper_step_sequencer.sv
// Directed bench for stepper_step_sequencer: APB programming, pulse timing/phase capture, abort, pause, reset, HALF mode.
module tb_stepper_step_sequencer;

  logic        PCLK = 1'b0;
  logic        PRESETN = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [7:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, STEP, DIR, IRQ;
  logic [3:0]  PHASE;

`ifdef STEPSEQ_HALFSTEP_EN
  localparam logic [31:0] CTRL5_RD = 32'h05;
  localparam logic [31:0] H_PH_A = 32'hC, H_PH_B = 32'h4, H_PH_C = 32'h6, H_PH_D = 32'h4;
`else
  localparam logic [31:0] CTRL5_RD = 32'h01;
  localparam logic [31:0] H_PH_A = 32'h4, H_PH_B = 32'h2, H_PH_C = 32'h1, H_PH_D = 32'h1;
`endif

  stepper_step_sequencer #(.PULSE_W(4), .CNT_W(32)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .STEP(STEP), .DIR(DIR), .PHASE(PHASE), .IRQ(IRQ)
  );

  always #5 PCLK = ~PCLK;

  // Pulse monitor: samples 1 time unit after each rising clock edge.
  int       cyc = 0, hi = 0;
  logic     step_prev = 1'b0, dir_prev = 1'b0;
  int       rise_t[$];
  logic [3:0] rise_ph[$];
  logic     rise_dirp[$];
  int       widths[$];

  always @(posedge PCLK) begin
    #1;
    cyc++;
    if (STEP && !step_prev) begin
      rise_t.push_back(cyc);
      rise_ph.push_back(PHASE);
      rise_dirp.push_back(dir_prev);
    end
    if (STEP) hi++;
    else if (step_prev) begin
      widths.push_back(hi);
      hi = 0;
    end
    step_prev = STEP;
    dir_prev  = DIR;
  end

  int n_checks = 0, n_pass = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    d = PRDATA;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic wait_rises(input string tag, input int target, input int budget);
    int n = 0;
    while (rise_t.size() < target && n < budget) begin
      @(negedge PCLK);
      n++;
    end
    check(tag, 32'(rise_t.size()), 32'(target));
  endtask

  initial begin
    int b, wb;

    // Reset state
    repeat (3) @(negedge PCLK);
    PRESETN = 1'b1;
    check("rst_step", 32'(STEP), 0);
    check("rst_phase", 32'(PHASE), 32'h8);
    check("rst_irq", 32'(IRQ), 0);
    check("rst_dir", 32'(DIR), 0);
    check("rst_pready", 32'(PREADY), 1);
    check("rst_pslverr", 32'(PSLVERR), 0);
    rd_check("rst_period", 8'h00, 0);
    rd_check("rst_steps", 8'h04, 0);
    rd_check("rst_ctrl", 8'h08, 0);
    rd_check("rst_status", 8'h0C, 0);

    // Forward move: 3 steps, period 10, IRQ enabled
    apb_write(8'h00, 10);
    apb_write(8'h08, 32'h13);
    b = rise_t.size(); wb = widths.size();
    apb_write(8'h04, 3);
    wait_rises("t1_rises", b + 3, 300);
    repeat (10) @(negedge PCLK);
    check("t1_sp01", 32'(rise_t[b+1] - rise_t[b]), 10);
    check("t1_sp12", 32'(rise_t[b+2] - rise_t[b+1]), 10);
    for (int i = 0; i < 3; i++) check("t1_width", 32'(widths[wb+i]), 4);
    check("t1_ph0", 32'(rise_ph[b]), 32'h4);
    check("t1_ph1", 32'(rise_ph[b+1]), 32'h2);
    check("t1_ph2", 32'(rise_ph[b+2]), 32'h1);
    check("t1_dir_lead", 32'(rise_dirp[b]), 1);
    check("t1_irq", 32'(IRQ), 1);
    rd_check("t1_status", 8'h0C, 32'h2);
    rd_check("t1_steps", 8'h04, 0);
    apb_write(8'h0C, 32'h2);
    check("t1_irq_clr", 32'(IRQ), 0);
    rd_check("t1_status_clr", 8'h0C, 0);

    // Period below minimum, backward move from index 0
    @(negedge PCLK); PRESETN = 1'b0;
    @(negedge PCLK); PRESETN = 1'b1;
    apb_write(8'h00, 2);
    apb_write(8'h08, 32'h01);
    b = rise_t.size();
    apb_write(8'h04, 2);
    wait_rises("t2_rises", b + 2, 300);
    repeat (10) @(negedge PCLK);
    check("t2_spacing", 32'(rise_t[b+1] - rise_t[b]), 6);
    check("t2_ph0", 32'(rise_ph[b]), 32'h1);
    check("t2_ph1", 32'(rise_ph[b+1]), 32'h2);
    check("t2_dir", 32'(DIR), 0);
    check("t2_irq", 32'(IRQ), 0);
    rd_check("t2_status", 8'h0C, 32'h2);
    apb_write(8'h0C, 32'h2);

    // Abort after 5 pulses
    apb_write(8'h00, 20);
    b = rise_t.size();
    apb_write(8'h04, 100);
    wait_rises("t3_rises", b + 5, 400);
    apb_write(8'h08, 32'h09);
    check("t3_step_low", 32'(STEP), 0);
    check("t3_spacing", 32'(rise_t[b+1] - rise_t[b]), 20);
    rd_check("t3_status", 8'h0C, 0);
    rd_check("t3_steps", 8'h04, 0);
    rd_check("t3_ctrl", 8'h08, 32'h01);
    check("t3_phase", 32'(PHASE), 32'h4);
    repeat (50) @(negedge PCLK);
    check("t3_no_more", 32'(rise_t.size() - b), 5);

    // Pause after first pulse
    apb_write(8'h00, 10);
    apb_write(8'h08, 32'h03);
    b = rise_t.size(); wb = widths.size();
    apb_write(8'h04, 4);
    wait_rises("t4_first", b + 1, 300);
    apb_write(8'h08, 32'h02);
    repeat (50) @(negedge PCLK);
    check("t4_paused", 32'(rise_t.size() - b), 1);
    check("t4_pulse_done", 32'(widths[wb]), 4);
    rd_check("t4_steps_mid", 8'h04, 3);
    rd_check("t4_busy", 8'h0C, 32'h1);
    apb_write(8'h08, 32'h03);
    wait_rises("t4_rises", b + 4, 300);
    repeat (10) @(negedge PCLK);
    check("t4_gap", 32'(rise_t[b+1] - rise_t[b] > 50), 1);
    for (int i = 1; i < 4; i++) check("t4_width", 32'(widths[wb+i]), 4);
    check("t4_ph3", 32'(rise_ph[b+3]), 32'h4);
    rd_check("t4_status", 8'h0C, 32'h2);

    // Reset mid-pulse
    apb_write(8'h00, 8);
    apb_write(8'h08, 32'h01);
    b = rise_t.size();
    apb_write(8'h04, 5);
    wait_rises("t5_rise", b + 1, 300);
    check("t5_step_hi", 32'(STEP), 1);
    #2 PRESETN = 1'b0;
    #1 check("t5_step_drop", 32'(STEP), 0);
    check("t5_phase", 32'(PHASE), 32'h8);
    @(negedge PCLK); PRESETN = 1'b1;
    rd_check("t5_steps", 8'h04, 0);
    rd_check("t5_period", 8'h00, 0);

    // HALF control bit and half-step phase sequence
    apb_write(8'h08, 32'h05);
    rd_check("t6_ctrl5", 8'h08, CTRL5_RD);
    apb_write(8'h00, 8);
    apb_write(8'h08, 32'h07);
    b = rise_t.size();
    apb_write(8'h04, 2);
    wait_rises("t6_rises", b + 2, 300);
    repeat (12) @(negedge PCLK);
    check("t6_spacing", 32'(rise_t[b+1] - rise_t[b]), 8);
    check("t6_ph0", 32'(rise_ph[b]), H_PH_A);
    check("t6_ph1", 32'(rise_ph[b+1]), H_PH_B);
    b = rise_t.size();
    apb_write(8'h04, 1);
    wait_rises("t6_rise3", b + 1, 300);
    repeat (12) @(negedge PCLK);
    check("t6_ph2", 32'(PHASE), H_PH_C);
    apb_write(8'h08, 32'h03);
    check("t6_remap", 32'(PHASE), H_PH_D);
    rd_check("t6_ctrl3", 8'h08, 32'h03);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
